// File: rtl/alu_issue_stage.sv
// RV32I issue register feeding the ALU: decodes operands/control and
// holds them in a 2-entry registered skid buffer with valid/ready.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32,
  parameter logic [3:0] ILLEGAL_CTL = 4'b0000
) (
  input  logic            clk_w_i,
  input  logic            rst_w_i_h,
  input  logic            flush_w_i_h,
  input  logic            in_valid_w_i,
  output logic            in_ready_w_o,
  input  logic [31:0]     instr_w_i,
  input  logic [XLEN-1:0] pc_w_i,
  input  logic [XLEN-1:0] rs1_data_w_i,
  input  logic [XLEN-1:0] rs2_data_w_i,
  output logic            out_valid_w_o,
  input  logic            out_ready_w_i,
  output logic [XLEN-1:0] a_data_w_o,
  output logic [XLEN-1:0] b_data_w_o,
  output logic [3:0]      alu_control_w_o,
  output logic            addi_sub_flag_w_o,
  output logic            is_branch_w_o,
  output logic [2:0]      branch_f3_w_o,
  output logic [4:0]      rd_w_o,
  output logic            illegal_w_o_h
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctl;
    logic            flag;
    logic            br;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic            ill;
  } issue_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  buf_state_t state_q;
  buf_state_t state_n;
  issue_t     out_q;
  issue_t     skid_q;
  issue_t     dec;
  logic       in_ready_q;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            f7b;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic            f3_sh;

  assign opc   = instr_w_i[6:0];
  assign f3    = instr_w_i[14:12];
  assign f7    = instr_w_i[31:25];
  assign f7b   = instr_w_i[30];
  assign imm_i = {{(XLEN-12){instr_w_i[31]}}, instr_w_i[31:20]};
  assign imm_u = {{(XLEN-32){instr_w_i[31]}}, instr_w_i[31:12], 12'b0};
  assign f3_sh = (f3 == 3'b000) || (f3 == 3'b101);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (opc == OPC_OP): begin
        dec.a    = rs1_data_w_i;
        dec.b    = rs2_data_w_i;
        dec.ctl  = {f7b & f3_sh, f3};
        dec.flag = 1'b1;
        dec.rd   = instr_w_i[11:7];
        dec.ill  = !((f7 == 7'h00) || ((f7 == 7'h20) && f3_sh));
      end
      (opc == OPC_OPIMM): begin
        dec.a    = rs1_data_w_i;
        dec.b    = imm_i;
        dec.ctl  = {(f3 == 3'b101) & f7b, f3};
        dec.rd   = instr_w_i[11:7];
        if (f3 == 3'b001)
          dec.ill = (f7 != 7'h00);
        else if (f3 == 3'b101)
          dec.ill = !((f7 == 7'h00) || (f7 == 7'h20));
      end
      (opc == OPC_BR): begin
        dec.a    = rs1_data_w_i;
        dec.b    = rs2_data_w_i;
        dec.ctl  = 4'b1000;
        dec.flag = 1'b1;
        dec.br   = 1'b1;
        dec.f3   = f3;
        dec.ill  = (f3 == 3'b010) || (f3 == 3'b011);
      end
      (opc == OPC_LUI): begin
        dec.b  = imm_u;
        dec.rd = instr_w_i[11:7];
      end
      (opc == OPC_AUIPC): begin
        dec.a  = pc_w_i;
        dec.b  = imm_u;
        dec.rd = instr_w_i[11:7];
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal entries still flow downstream, but with inert operands.
    if (dec.ill) begin
      dec     = '0;
      dec.ctl = ILLEGAL_CTL;
      dec.ill = 1'b1;
    end
  end

  logic accept;
  logic drain;
  logic load_in;
  logic load_skid;
  logic move_skid;

  assign accept = in_valid_w_i & in_ready_q;
  assign drain  = (state_q != EMPTY) & out_ready_w_i;

  always_comb begin
    state_n   = state_q;
    load_in   = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush_w_i_h) begin
      state_n = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_n = ONE;
            load_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end else if (accept && drain) begin
            load_in = 1'b1;
          end else if (drain) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_n   = ONE;
            move_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_w_i) begin
    if (rst_w_i_h) begin
      state_q    <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_n;
      in_ready_q <= (state_n != FULL);
      if (load_in)
        out_q <= dec;
      else if (move_skid)
        out_q <= skid_q;
      if (load_skid)
        skid_q <= dec;
    end
  end

  assign in_ready_w_o      = in_ready_q;
  assign out_valid_w_o     = (state_q != EMPTY);
  assign a_data_w_o        = out_q.a;
  assign b_data_w_o        = out_q.b;
  assign alu_control_w_o   = out_q.ctl;
  assign addi_sub_flag_w_o = out_q.flag;
  assign is_branch_w_o     = out_q.br;
  assign branch_f3_w_o     = out_q.f3;
  assign rd_w_o            = out_q.rd;
  assign illegal_w_o_h     = out_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, skid buffering,
// flush and reset behaviour.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'h0;
  logic [31:0] pc = 32'h0;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] a_data;
  logic [31:0] b_data;
  logic [3:0]  ctl;
  logic        flag;
  logic        is_br;
  logic [2:0]  br_f3;
  logic [4:0]  rd;
  logic        ill;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk_w_i(clk),
    .rst_w_i_h(rst),
    .flush_w_i_h(flush),
    .in_valid_w_i(in_valid),
    .in_ready_w_o(in_ready),
    .instr_w_i(instr),
    .pc_w_i(pc),
    .rs1_data_w_i(rs1),
    .rs2_data_w_i(rs2),
    .out_valid_w_o(out_valid),
    .out_ready_w_i(out_ready),
    .a_data_w_o(a_data),
    .b_data_w_o(b_data),
    .alu_control_w_o(ctl),
    .addi_sub_flag_w_o(flag),
    .is_branch_w_o(is_br),
    .branch_f3_w_o(br_f3),
    .rd_w_o(rd),
    .illegal_w_o_h(ill)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_hs: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    total++;
    if (a_data !== 32'h0 || b_data !== 32'h0 || ctl !== 4'h0 || flag !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: a=%h b=%h ctl=%b f=%b want 0", a_data, b_data, ctl, flag);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    in_valid = 1'b1;
    instr = 32'h002081B3;
    rs1 = 32'd5;
    rs2 = 32'd7;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || ctl !== 4'b0000 || a_data !== 32'd5 ||
        b_data !== 32'd7 || rd !== 5'd3 || flag !== 1'b1 || ill !== 1'b0) begin
      bad++;
      $display("FAIL add: v=%b ctl=%b a=%0d b=%0d rd=%0d f=%b ill=%b want 1 0000 5 7 3 1 0",
               out_valid, ctl, a_data, b_data, rd, flag, ill);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_drain: v=%b want 0", out_valid);
    end
  endtask

  task automatic test_sub_srai();
    out_ready = 1'b1;
    in_valid = 1'b1;
    instr = 32'h402081B3;
    rs1 = 32'd9;
    rs2 = 32'd4;
    tick();
    instr = 32'h4030D093;
    total++;
    if (ctl !== 4'b1000 || flag !== 1'b1 || a_data !== 32'd9 || b_data !== 32'd4) begin
      bad++;
      $display("FAIL sub: ctl=%b f=%b a=%0d b=%0d want 1000 1 9 4", ctl, flag, a_data, b_data);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || ctl !== 4'b1101 || b_data[4:0] !== 5'd3 ||
        b_data !== 32'h403 || flag !== 1'b0 || rd !== 5'd1) begin
      bad++;
      $display("FAIL srai: v=%b ctl=%b b=%h f=%b rd=%0d want 1 1101 403 0 1",
               out_valid, ctl, b_data, flag, rd);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    rs1 = 32'h0;
    in_valid = 1'b1;
    instr = 32'h00100093;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || b_data !== 32'd1) begin
      bad++;
      $display("FAIL bp_first: rdy=%b v=%b b=%0d want 1 1 1", in_ready, out_valid, b_data);
    end
    instr = 32'h00200093;
    tick();
    instr = 32'h00300093;
    total++;
    if (in_ready !== 1'b0 || b_data !== 32'd1) begin
      bad++;
      $display("FAIL bp_full: rdy=%b b=%0d want 0 1", in_ready, b_data);
    end
    tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || b_data !== 32'd1) begin
      bad++;
      $display("FAIL bp_hold: rdy=%b v=%b b=%0d want 0 1 1", in_ready, out_valid, b_data);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || b_data !== 32'd2) begin
      bad++;
      $display("FAIL bp_rel1: rdy=%b v=%b b=%0d want 1 1 2", in_ready, out_valid, b_data);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || b_data !== 32'd3) begin
      bad++;
      $display("FAIL bp_rel2: v=%b b=%0d want 1 3", out_valid, b_data);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_empty: v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    rs1 = 32'h0;
    in_valid = 1'b1;
    instr = 32'h00A00093;
    tick();
    instr = 32'h00B00093;
    tick();
    instr = 32'h00C00093;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush: v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_absent: v=%b b=%0d want v=0", out_valid, b_data);
    end
  endtask

  task automatic test_imm_upper();
    out_ready = 1'b1;
    in_valid = 1'b1;
    instr = 32'hFFF00093;
    rs1 = 32'h55;
    tick();
    instr = 32'h12345097;
    pc = 32'h100;
    total++;
    if (b_data !== 32'hFFFFFFFF || ctl !== 4'b0000 || a_data !== 32'h55 || flag !== 1'b0) begin
      bad++;
      $display("FAIL addi_m1: a=%h b=%h ctl=%b f=%b want 55 ffffffff 0000 0",
               a_data, b_data, ctl, flag);
    end
    tick();
    instr = 32'h123450B7;
    total++;
    if (a_data !== 32'h100 || b_data !== 32'h12345000 || ctl !== 4'b0000 || rd !== 5'd1) begin
      bad++;
      $display("FAIL auipc: a=%h b=%h ctl=%b rd=%0d want 100 12345000 0000 1",
               a_data, b_data, ctl, rd);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (a_data !== 32'h0 || b_data !== 32'h12345000 || ill !== 1'b0) begin
      bad++;
      $display("FAIL lui: a=%h b=%h ill=%b want 0 12345000 0", a_data, b_data, ill);
    end
    tick();
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    in_valid = 1'b1;
    instr = 32'h00209063;
    rs1 = 32'h11;
    rs2 = 32'h22;
    tick();
    instr = 32'h0020A063;
    total++;
    if (is_br !== 1'b1 || ctl !== 4'b1000 || flag !== 1'b1 || rd !== 5'd0 ||
        br_f3 !== 3'b001 || a_data !== 32'h11 || b_data !== 32'h22 || ill !== 1'b0) begin
      bad++;
      $display("FAIL bne: br=%b ctl=%b f=%b rd=%0d f3=%b a=%h b=%h ill=%b",
               is_br, ctl, flag, rd, br_f3, a_data, b_data, ill);
    end
    tick();
    instr = 32'h0040A1B3;
    total++;
    if (ill !== 1'b1 || ctl !== 4'b0000) begin
      bad++;
      $display("FAIL br_ill: ill=%b ctl=%b want 1 0000", ill, ctl);
    end
    tick();
    instr = 32'h4020A1B3;
    total++;
    if (ill !== 1'b0 || ctl !== 4'b0010 || rd !== 5'd3) begin
      bad++;
      $display("FAIL slt: ill=%b ctl=%b rd=%0d want 0 0010 3", ill, ctl, rd);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (ill !== 1'b1 || ctl !== 4'b0000) begin
      bad++;
      $display("FAIL op_f7_ill: ill=%b ctl=%b want 1 0000", ill, ctl);
    end
    tick();
  endtask

  task automatic test_illegal_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'h0000007F;
    rs1 = 32'h77;
    rs2 = 32'h88;
    tick();
    total++;
    if (ill !== 1'b1 || ctl !== 4'b0000 || a_data !== 32'h0 ||
        b_data !== 32'h0 || rd !== 5'd0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL illegal: ill=%b ctl=%b a=%h b=%h rd=%0d v=%b",
               ill, ctl, a_data, b_data, rd, out_valid);
    end
    instr = 32'h00100093;
    tick();
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre_full: rdy=%b want 0", in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ill !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: v=%b rdy=%b ill=%b want 0 1 0", out_valid, in_ready, ill);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_after: v=%b want 0", out_valid);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_sub_srai();
    test_backpressure();
    test_flush();
    test_imm_upper();
    test_branch();
    test_illegal_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
